// File: rtl/mem_stall_ctrl_if.sv
// Handshake between the MEM stage (master) and the memory-stall sequencer (slave).
// misaligned_trap exists only when MEM_STALL_MISALIGN_TRAP_EN is defined.
interface mem_stall_ctrl_if;
  logic       mem_req;
  logic       mem_is_load;
  logic [1:0] mem_size;
  logic [1:0] mem_addr_lo;
  logic       stall_pc;
  logic       ignore_curr_inst;
  logic       pipe_hold;
  logic       mem_done;
`ifdef MEM_STALL_MISALIGN_TRAP_EN
  logic       misaligned_trap;
`endif

  modport master (
    output mem_req, mem_is_load, mem_size, mem_addr_lo,
    input  stall_pc, ignore_curr_inst, pipe_hold, mem_done
`ifdef MEM_STALL_MISALIGN_TRAP_EN
    , input misaligned_trap
`endif
  );

  modport slave (
    input  mem_req, mem_is_load, mem_size, mem_addr_lo,
    output stall_pc, ignore_curr_inst, pipe_hold, mem_done
`ifdef MEM_STALL_MISALIGN_TRAP_EN
    , output misaligned_trap
`endif
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Steals the shared single-port memory for a MEM-stage load/store, holds the pipe, then masks stale fetches.
// Define MEM_STALL_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stall_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  mem_stall_ctrl_if.slave bus
);
  localparam int            CW     = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT    = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_REFILL
`ifdef MEM_STALL_MISALIGN_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          stall_pc_q;
  logic          ignore_q;
  logic          pipe_hold_q;
  logic          mem_done_q;

  // Access attributes only matter for the trap check; the sequence itself is the same for every access.
`ifdef MEM_STALL_MISALIGN_TRAP_EN
  logic trap_q;
  logic misaligned;
  logic unused_inputs;
  assign misaligned    = (bus.mem_size == 2'd1) ? bus.mem_addr_lo[0]
                                                : (bus.mem_size[1] & (|bus.mem_addr_lo));
  assign unused_inputs = bus.mem_is_load;
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.mem_is_load, bus.mem_size, bus.mem_addr_lo};
`endif

  // Outputs are registered: each transition loads the output values of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_pc_q  <= 1'b0;
      ignore_q    <= 1'b0;
      pipe_hold_q <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef MEM_STALL_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      // NOTE: these defaults are non-blocking too; a later <= in the same pass overrides them cleanly.
      stall_pc_q  <= 1'b0;
      ignore_q    <= 1'b0;
      pipe_hold_q <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef MEM_STALL_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (bus.mem_req) begin
`ifdef MEM_STALL_MISALIGN_TRAP_EN
            if (misaligned) begin
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              stall_pc_q  <= 1'b1;
              pipe_hold_q <= 1'b1;
            end
`else
            state_q     <= S_ISSUE;
            stall_pc_q  <= 1'b1;
            pipe_hold_q <= 1'b1;
`endif
          end
        end

        S_ISSUE: begin
          cnt_q <= LAT_M1;
          if (MEM_LATENCY == 1) begin
            state_q    <= S_RESP;
            stall_pc_q <= 1'b1;
            ignore_q   <= 1'b1;
            mem_done_q <= 1'b1;
          end else begin
            state_q     <= S_WAIT;
            stall_pc_q  <= 1'b1;
            pipe_hold_q <= 1'b1;
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q    <= S_RESP;
            stall_pc_q <= 1'b1;
            ignore_q   <= 1'b1;
            mem_done_q <= 1'b1;
          end else begin
            stall_pc_q  <= 1'b1;
            pipe_hold_q <= 1'b1;
          end
        end

        S_RESP: begin
          cnt_q    <= LAT;
          state_q  <= S_REFILL;
          ignore_q <= 1'b1;
        end

        // Fetches issued during the stall return over the next L cycles and must be masked.
        S_REFILL: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q <= S_IDLE;
          end else begin
            ignore_q <= 1'b1;
          end
        end

`ifdef MEM_STALL_MISALIGN_TRAP_EN
        S_TRAP: state_q <= S_IDLE;
`endif

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.stall_pc         = stall_pc_q;
  assign bus.ignore_curr_inst = ignore_q;
  assign bus.pipe_hold        = pipe_hold_q;
  assign bus.mem_done         = mem_done_q;
`ifdef MEM_STALL_MISALIGN_TRAP_EN
  assign bus.misaligned_trap  = trap_q;
`endif
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl at MEM_LATENCY 1, 2 and 3 side by side.
// Observed nibble per DUT is {stall_pc, ignore_curr_inst, pipe_hold, mem_done}.
module tb_mem_stall_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst;
  logic [2:0]      req;
  logic [2:0]      is_load;
  logic [2:0][1:0] size;
  logic [2:0][1:0] addr_lo;
  logic [2:0][3:0] obs;
  logic [2:0]      trap;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stall_ctrl_if bus ();
    assign bus.mem_req     = req[g];
    assign bus.mem_is_load = is_load[g];
    assign bus.mem_size    = size[g];
    assign bus.mem_addr_lo = addr_lo[g];
    assign obs[g] = {bus.stall_pc, bus.ignore_curr_inst, bus.pipe_hold, bus.mem_done};
`ifdef MEM_STALL_MISALIGN_TRAP_EN
    assign trap[g] = bus.misaligned_trap;
`else
    assign trap[g] = 1'b0;
`endif
    mem_stall_ctrl #(.MEM_LATENCY(g + 1)) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pat holds n expected nibbles, first cycle in the most significant one; req drops after 'hold' cycles.
  task automatic expect_seq(input int d, input string tag, input logic [63:0] pat, input int n,
                            input int hold);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s[%0d]", tag, i), obs[d], pat[4*(n-1-i) +: 4]);
      if (i + 1 >= hold) req[d] = 1'b0;
    end
  endtask

  initial begin
    rst     = 3'b111;
    req     = 3'b111;
    is_load = 3'b111;
    size    = {2'd2, 2'd2, 2'd2};
    addr_lo = '0;

    // Reset held two cycles with requests pending.
    for (int c = 0; c < 2; c++) begin
      step();
      for (int d = 0; d < 3; d++) check($sformatf("reset_c%0d_L%0d", c, d + 1), obs[d], 4'h0);
    end
    rst = 3'b000;
    req = 3'b000;
    step();
    for (int d = 0; d < 3; d++) check($sformatf("idle_after_rst_L%0d", d + 1), obs[d], 4'h0);

    // L=1 load: ISSUE, RESP, REFILL, IDLE.
    req[0] = 1'b1;
    expect_seq(0, "l1_load", 64'hAD40, 4, 1);

    // L=3 store held through pipe_hold.
    is_load[2] = 1'b0;
    req[2]     = 1'b1;
    expect_seq(2, "l3_store", 64'hAAAD4440, 8, 3);
    is_load[2] = 1'b1;

    // L=2 back-to-back with req held: ISSUEs six cycles apart.
    req[1] = 1'b1;
    expect_seq(1, "l2_b2b", 64'hAAD440AAD440, 12, 7);
    step();
    check("l2_b2b_quiet", obs[1], 4'h0);

    // L=3 reset during WAIT, then a fresh access.
    req[2] = 1'b1;
    step();
    check("l3_rst_issue", obs[2], 4'hA);
    step();
    check("l3_rst_wait", obs[2], 4'hA);
    rst[2] = 1'b1;
    step();
    check("l3_rst_cleared", obs[2], 4'h0);
    rst[2] = 1'b0;
    req[2] = 1'b0;
    step();
    check("l3_rst_idle", obs[2], 4'h0);
    req[2] = 1'b1;
    expect_seq(2, "l3_after_rst", 64'hAAAD4440, 8, 3);

    // Misaligned word access (addr_lo=2) on L=1.
    size[0]    = 2'd2;
    addr_lo[0] = 2'd2;
    req[0]     = 1'b1;
`ifdef MEM_STALL_MISALIGN_TRAP_EN
    step();
    check("trap_word_pulse", {3'b000, trap[0]}, 4'h1);
    check("trap_word_outs", obs[0], 4'h0);
    req[0] = 1'b0;
    step();
    check("trap_word_clear", {3'b000, trap[0]}, 4'h0);
    check("trap_word_idle", obs[0], 4'h0);

    size[0]    = 2'd1;
    addr_lo[0] = 2'd1;
    req[0]     = 1'b1;
    step();
    check("trap_half_pulse", {3'b000, trap[0]}, 4'h1);
    req[0] = 1'b0;
    step();
    check("trap_half_clear", {3'b000, trap[0]}, 4'h0);

    addr_lo[0] = 2'd2;
    req[0]     = 1'b1;
    expect_seq(0, "half_aligned", 64'hAD40, 4, 1);

    size[0]    = 2'd0;
    addr_lo[0] = 2'd3;
    req[0]     = 1'b1;
    expect_seq(0, "byte_any", 64'hAD40, 4, 1);
`else
    expect_seq(0, "misaligned_issued", 64'hAD40, 4, 1);
`endif
    size[0]    = 2'd2;
    addr_lo[0] = 2'd0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
